// File: rtl/estu_pkg.sv
// Shared estu definitions: drain FSM encoding and frame-buffer geometry helpers.
package estu_pkg;

  localparam logic [0:0] ST_FILL  = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

  // 8-bit samples are packed two per 16-bit word.
  function automatic bit simd_mode(input int dw);
    return dw == 8;
  endfunction

  function automatic int buf_depth(input int channels, input int dw);
    return simd_mode(dw) ? channels / 2 : channels;
  endfunction

endpackage

// File: rtl/BRAM_singlePort_readFirst.sv
// Single-port block RAM, read-first: a write cycle returns the previous word on dout.
module BRAM_singlePort_readFirst #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 128,
  parameter int AW    = 7
) (
  input  logic             clk,
  input  logic             en,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      dout <= mem[addr];
      if (we) mem[addr] <= din;
    end
  end

endmodule

// File: rtl/output_buffer.sv
// Frame output buffer: fills one RAM frame from the core, then drains it in address order
// through a one-deep prefetch stage so a continuously ready sink sees one word per cycle.
module output_buffer
  import estu_pkg::*;
#(
  parameter int CHANNELS = 128,
  parameter int DW       = 15,
  localparam int DEPTH   = buf_depth(CHANNELS, DW),
  localparam int AW      = clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [15:0]   out_data,
  input  logic          out_ready,
  output logic          out_last,
  output logic          overflow,
  input  logic          external_access_en,
  input  logic [AW-1:0] external_addr,
  output logic [15:0]   external_data_out,
  output logic [0:0]    dbg_state
);

  localparam bit            SIMD      = simd_mode(DW);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  logic [0:0]    state;
  logic          fill, drain;
  logic [AW-1:0] wptr, rptr, ram_addr;
  logic          we, issue, load_out, ext_fire, ext_pend;
  logic          rd_done, rd_valid, rd_last;
  logic [15:0]   wr_word, ram_dout, ext_hold;

  // Handshakes: a word moves on any rising edge where valid && ready; a valid producer
  // holds its data unchanged until that edge, and ready never depends on valid.
  assign fill      = (state == ST_FILL);
  assign drain     = (state == ST_DRAIN);
  assign in_ready  = fill;
  assign dbg_state = state;

  // rd_valid marks an unconsumed word on the RAM output; dout only moves when en is set.
  assign load_out = rd_valid && (!out_valid || out_ready);
  assign issue    = drain && !rd_done && (!rd_valid || load_out);
  assign ext_fire = fill && external_access_en && !we;
  assign ram_addr = drain ? rptr : (we ? wptr : external_addr);

  if (SIMD) begin : g_simd
    logic       half_q;
    logic [7:0] lo_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        half_q <= 1'b0;
        lo_q   <= '0;
      end else if (fill && in_valid) begin
        half_q <= !half_q;
        if (!half_q) lo_q <= in_data[7:0];
      end
    end

    assign we      = fill && in_valid && half_q;
    assign wr_word = {in_data[7:0], lo_q};
  end else begin : g_word
    assign we      = fill && in_valid;
    assign wr_word = 16'($signed(in_data));
  end

  BRAM_singlePort_readFirst #(.WIDTH(16), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk  (clk),
    .en   (we || issue || ext_fire),
    .we   (we),
    .addr (ram_addr),
    .din  (wr_word),
    .dout (ram_dout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_FILL;
      wptr  <= '0;
    end else if (fill) begin
      if (we) begin
        wptr <= (wptr == LAST_ADDR) ? '0 : wptr + AW'(1);
        if (wptr == LAST_ADDR) state <= ST_DRAIN;
      end
    end else if (out_valid && out_ready && out_last) begin
      state <= ST_FILL;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr     <= '0;
      rd_done  <= 1'b0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
    end else if (fill) begin
      rptr     <= '0;
      rd_done  <= 1'b0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
    end else begin
      if (issue) begin
        rptr    <= (rptr == LAST_ADDR) ? '0 : rptr + AW'(1);
        rd_done <= (rptr == LAST_ADDR);
        rd_last <= (rptr == LAST_ADDR);
      end
      rd_valid <= issue || (rd_valid && !load_out);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else if (load_out) begin
      out_valid <= 1'b1;
      out_last  <= rd_last;
      out_data  <= ram_dout;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
      ext_pend <= 1'b0;
      ext_hold <= '0;
    end else begin
      if (in_valid && !in_ready) overflow <= 1'b1;
      ext_pend <= ext_fire;
      if (ext_pend) ext_hold <= ram_dout;
    end
  end

  // Host read data follows the RAM output in the cycle after the request, then holds.
  assign external_data_out = ext_pend ? ram_dout : ext_hold;

endmodule

// File: doc/output_buffer.md
OUTPUT_BUFFER -- requirements
Module: output_buffer

Interface
REQ-001 SHALL have parameter CHANNELS, default 128, meaning samples per frame (power of two, >=4).
REQ-002 SHALL have parameter DW, default 15, meaning input sample width; DW==8 selects SIMD packing.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  core result sample present.
REQ-007 in_data  input  DW  signed core result sample.
REQ-008 in_ready  output  1  buffer accepts samples (FILL state).
REQ-009 out_valid  output  1  out_data holds a frame word.
REQ-010 out_data  output  16  signed frame word to host/next stage.
REQ-011 out_ready  input  1  downstream accepts out_data.
REQ-012 out_last  output  1  current out word is the last of the frame.
REQ-013 overflow  output  1  sticky: a sample was offered while in_ready=0.
REQ-014 external_access_en  input  1  host random read request.
REQ-015 external_addr  input  clog2(DEPTH)  host read word address.
REQ-016 external_data_out  output  16  host read data.

Function
REQ-017 DEPTH SHALL be CHANNELS/2 when DW==8, else CHANNELS; storage is one 16-bit single-clock RAM, 1-cycle read latency.
REQ-018 Non-SIMD: each accepted sample SHALL be sign-extended to 16 bits and written to one word.
REQ-019 SIMD: first sample of a pair SHALL go to bits [7:0], second to [15:8]; word written when the second arrives.
REQ-020 Transfer SHALL occur when in_valid && in_ready; write pointer increments per written word.
REQ-021 States SHALL be FILL and DRAIN; FILL: in_ready=1, out_valid=0; DRAIN: in_ready=0.
REQ-022 FILL->DRAIN SHALL occur on the cycle the word at address DEPTH-1 is written; write pointer wraps to 0.
REQ-023 First out_valid SHALL assert 2 cycles after the final write (read issue + output register).
REQ-024 Words SHALL be emitted in address order 0..DEPTH-1; read pointer advances on out_valid && out_ready.
REQ-025 out_data/out_last SHALL be held stable while out_valid && !out_ready.
REQ-026 With out_ready held high, one word SHALL be emitted per cycle (prefetch/skid, no bubbles).
REQ-027 out_last SHALL be 1 only with word DEPTH-1; its handshake returns to FILL, in_ready=1 next cycle.
REQ-028 in_valid while in_ready=0 SHALL be dropped and set overflow; only reset clears overflow.
REQ-029 external_access_en SHALL be honoured only in FILL with no write that cycle; external_data_out valid next cycle; otherwise ignored and external_data_out holds.
REQ-030 Partial SIMD pair at frame end SHALL not exist (CHANNELS even); no other flush mechanism.

Reset
REQ-031 rst_n low SHALL immediately force FILL, pointers 0, SIMD half-word flag 0, out_valid=0, out_last=0, out_data=0, overflow=0, external_data_out=0, in_ready=1 after release.
REQ-032 Reset mid-DRAIN SHALL abandon the frame; RAM contents need not be cleared.

Structure
REQ-033 clog2 function, state encoding (FILL, DRAIN) and SIMD/DEPTH derivation SHALL live in the shared estu package.
REQ-034 The RAM SHALL be the existing BRAM_singlePort_readFirst sub-module; FSM, packing and output skid stay in output_buffer.

Verification
REQ-035 DW=15, CHANNELS=4, samples -3,5,7,-1 back-to-back, out_ready=1 -> out_data 0xFFFD,0x0005,0x0007,0xFFFF on consecutive cycles, out_last on 4th, first out_valid 2 cycles after 4th write.
REQ-036 DW=8, CHANNELS=4, samples 0x11,0x22,0x33,0x44 -> words 0x2211,0x4433, out_last on second.
REQ-037 Drain with out_ready toggling 1,0,0,1 -> each word held while stalled, no word skipped or duplicated.
REQ-038 in_valid=1 during DRAIN -> sample dropped, overflow=1 and stays 1 through next frame until rst_n low.
REQ-039 rst_n pulsed low after 2 of 4 drained words -> out_valid=0 at once, in_ready=1 after release, next frame emits from address 0.
REQ-040 FILL, external_access_en=1, external_addr=1 after prior frame with word1=0x0005 -> external_data_out=0x0005 next cycle.
